// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, widths and parameter defaults for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DPW                = 32;
    localparam int unsigned STARVE_MAX_DEFAULT = 4;
    localparam int unsigned TIMEOUT_DEFAULT    = 64;
    localparam int unsigned STARVE_W           = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_BUSY = 2'd1,
        ARB_DM_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } arb_src_t;

    typedef struct packed {
        logic           we;
        logic [DPW-1:0] addr;
        logic [DPW-1:0] wdata;
    } mem_cmd_t;

    // Command presented to memory for a given grant; fetch is always a plain read.
    function automatic mem_cmd_t makeCmd(
        input arb_src_t       src,
        input logic           dmWe,
        input logic [DPW-1:0] dmAddr,
        input logic [DPW-1:0] dmWdata,
        input logic [DPW-1:0] ifAddr
    );
        mem_cmd_t cmd;
        if (src == SRC_DM) begin
            cmd.we    = dmWe;
            cmd.addr  = dmAddr;
            cmd.wdata = dmWdata;
        end else begin
            cmd.we    = 1'b0;
            cmd.addr  = ifAddr;
            cmd.wdata = '0;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Busy-cycle watchdog for the arbiter; only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module arb_timeout_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // count holds the number of busy cycles already completed, so expiry lands on cycle TIMEOUT
    always_ff @(posedge clk) begin : countReg
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !expire_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire_c = enable & (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stages with fetch starvation guard.
// Optional busy-state watchdog and bus_err flag enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           if_req,
    input  logic [DPW-1:0] if_addr,
    output logic [DPW-1:0] if_rdata,
    output logic           if_valid,
    input  logic           dm_req,
    input  logic           dm_we,
    input  logic [DPW-1:0] dm_addr,
    input  logic [DPW-1:0] dm_wdata,
    output logic [DPW-1:0] dm_rdata,
    output logic           dm_valid,
    output logic           mem_req,
    output logic           mem_we,
    output logic [DPW-1:0] mem_addr,
    output logic [DPW-1:0] mem_wdata,
    input  logic [DPW-1:0] mem_rdata,
    input  logic           mem_ack,
    output logic           stall_if,
    output logic           stall_dm,
    output logic           bus_err
);

    localparam logic [1:0] IDLE    = 2'(ARB_IDLE);
    localparam logic [1:0] IF_BUSY = 2'(ARB_IF_BUSY);
    localparam logic [1:0] DM_BUSY = 2'(ARB_DM_BUSY);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [1:0]          state;
    logic [1:0]          nextState;
    logic [STARVE_W-1:0] starveCnt;
    logic [STARVE_W-1:0] starveNext;
    logic                ifElig;
    logic                dmElig;
    logic                grant;
    arb_src_t            grantSrc;
    mem_cmd_t            grantCmd;
    logic                finish;
    logic                timedOut;
    logic                expireC;
    logic [DPW-1:0]      finishData;

    // A requester is not re-arbitrated in its own completion cycle
    assign ifElig = if_req & ~if_valid;
    assign dmElig = dm_req & ~dm_valid;

    assign stall_if = if_req & ~if_valid;
    assign stall_dm = dm_req & ~dm_valid;

    always_comb begin : nextStateLogic
        nextState  = state;
        starveNext = starveCnt;
        grant      = 1'b0;
        grantSrc   = SRC_IF;
        finish     = 1'b0;
        timedOut   = 1'b0;
        case (state)
            IDLE: begin
                if (dmElig && !(ifElig && starveCnt == STARVE_LIM)) begin
                    grant     = 1'b1;
                    grantSrc  = SRC_DM;
                    nextState = DM_BUSY;
                    if (ifElig) begin
                        starveNext = starveCnt + STARVE_W'(1);
                    end
                end else if (ifElig) begin
                    grant      = 1'b1;
                    grantSrc   = SRC_IF;
                    nextState  = IF_BUSY;
                    starveNext = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                // A real ack always beats a simultaneous watchdog expiry
                if (mem_ack) begin
                    finish    = 1'b1;
                    nextState = IDLE;
                end else if (expireC) begin
                    finish    = 1'b1;
                    timedOut  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign grantCmd   = makeCmd(grantSrc, dm_we, dm_addr, dm_wdata, if_addr);
    assign finishData = timedOut ? '0 : mem_rdata;

    always_ff @(posedge clk) begin : stateReg
        if (!rst_n) begin
            state     <= IDLE;
            starveCnt <= '0;
        end else begin
            state     <= nextState;
            starveCnt <= starveNext;
        end
    end

    // Memory command, completion pulses and captured read data
    always_ff @(posedge clk) begin : outputReg
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            bus_err   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (grant) begin
                mem_req   <= 1'b1;
                mem_we    <= grantCmd.we;
                mem_addr  <= grantCmd.addr;
                mem_wdata <= grantCmd.wdata;
            end
            if (finish) begin
                mem_req <= 1'b0;
                if (state == DM_BUSY) begin
                    dm_valid <= 1'b1;
                    dm_rdata <= mem_we ? '0 : finishData;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= finishData;
                end
            end
            if (timedOut) begin
                bus_err <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    arb_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) uTimer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (grant),
        .enable   (state != IDLE),
        .expire_c (expireC)
    );
`else
    logic unusedTimeout;
    assign expireC       = 1'b0;
    assign unusedTimeout = ^32'(TIMEOUT);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, starvation/timeout sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned STARVE = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TOUT = 8;
`else
    localparam int unsigned TOUT = 64;
`endif

    typedef struct packed {
        logic        rst;
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dmReq;
        logic        dmWe;
        logic [31:0] dmAddr;
        logic [31:0] dmWdata;
        logic        ack;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        memReq;
        logic        memWe;
        logic [31:0] memAddr;
        logic [31:0] memWdata;
        logic        ifValid;
        logic [31:0] ifRdata;
        logic        dmValid;
        logic [31:0] dmRdata;
        logic        stallIf;
        logic        stallDm;
        logic        busErr;
    } outs_t;

    typedef struct {
        in_t   stim;
        outs_t exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_dm;
    logic        bus_err;

    int errCnt = 0;
    int chkCnt = 0;
    vec_t tbl[$];

    // reference model state: expected registered outputs plus arbitration bookkeeping
    outs_t m;
    int    mLoss;
    int    mBusyCyc;
    bit    mOwnerDm;

    mem_port_arbiter #(
        .STARVE_MAX (STARVE),
        .TIMEOUT    (TOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_dm  (stall_dm),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic in_t vi(int rst, int ir, logic [31:0] ia, int dr, int dw,
                               logic [31:0] da, logic [31:0] dd, int ak, logic [31:0] rd);
        in_t v;
        v.rst = (rst != 0); v.ifReq = (ir != 0); v.ifAddr = ia;
        v.dmReq = (dr != 0); v.dmWe = (dw != 0); v.dmAddr = da; v.dmWdata = dd;
        v.ack = (ak != 0); v.rdata = rd;
        return v;
    endfunction

    function automatic outs_t vo(int rq, int we, logic [31:0] ad, logic [31:0] wd, int iv,
                                 logic [31:0] ir, int dv, logic [31:0] dr, int si, int sd, int be);
        outs_t o;
        o.memReq = (rq != 0); o.memWe = (we != 0); o.memAddr = ad; o.memWdata = wd;
        o.ifValid = (iv != 0); o.ifRdata = ir; o.dmValid = (dv != 0); o.dmRdata = dr;
        o.stallIf = (si != 0); o.stallDm = (sd != 0); o.busErr = (be != 0);
        return o;
    endfunction

    function automatic void add(in_t s, outs_t e);
        vec_t v;
        v.stim = s;
        v.exp  = e;
        tbl.push_back(v);
    endfunction

    task automatic applyIn(in_t v);
        rst_n = v.rst; if_req = v.ifReq; if_addr = v.ifAddr;
        dm_req = v.dmReq; dm_we = v.dmWe; dm_addr = v.dmAddr; dm_wdata = v.dmWdata;
        mem_ack = v.ack; mem_rdata = v.rdata;
    endtask

    function automatic outs_t sample();
        return {mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata,
                dm_valid, dm_rdata, stall_if, stall_dm, bus_err};
    endfunction

    function automatic void chkOuts(string name, int idx, outs_t act, outs_t exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endfunction

    function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Transaction-level reference: one call per clock edge using the inputs of that cycle
    function automatic void modelStep();
        bit ifWants, dmWants, fetchForced, ackTaken, expired;
        logic [31:0] data;
        if (!rst_n) begin
            m = '0;
            mLoss = 0;
            mBusyCyc = 0;
            return;
        end
        ifWants = if_req && !m.ifValid;
        dmWants = dm_req && !m.dmValid;
        m.ifValid = 1'b0;
        m.dmValid = 1'b0;
        if (!m.memReq) begin
            fetchForced = ifWants && dmWants && (mLoss >= int'(STARVE));
            if (dmWants && !fetchForced) begin
                if (ifWants) mLoss++;
                mOwnerDm = 1'b1;
                m.memReq = 1'b1; m.memWe = dm_we; m.memAddr = dm_addr; m.memWdata = dm_wdata;
                mBusyCyc = 0;
            end else if (ifWants) begin
                mLoss = 0;
                mOwnerDm = 1'b0;
                m.memReq = 1'b1; m.memWe = 1'b0; m.memAddr = if_addr; m.memWdata = '0;
                mBusyCyc = 0;
            end
        end else begin
            mBusyCyc++;
            ackTaken = mem_ack;
            expired  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            expired = !mem_ack && (mBusyCyc == int'(TOUT));
`endif
            if (ackTaken || expired) begin
                data = expired ? 32'h0 : mem_rdata;
                m.memReq = 1'b0;
                if (expired) m.busErr = 1'b1;
                if (mOwnerDm) begin
                    m.dmValid = 1'b1;
                    m.dmRdata = m.memWe ? 32'h0 : data;
                end else begin
                    m.ifValid = 1'b1;
                    m.ifRdata = data;
                end
            end
        end
    endfunction

    function automatic void buildTable();
        // reset, then a stale ack in idle
        add(vi(0,0,0,0,0,0,0,0,0),                   vo(0,0,0,0,0,0,0,0,0,0,0));
        add(vi(1,0,0,0,0,0,0,1,32'hBAD0BAD0),        vo(0,0,0,0,0,0,0,0,0,0,0));
        add(vi(1,0,0,0,0,0,0,0,0),                   vo(0,0,0,0,0,0,0,0,0,0,0));
        // single fetch, ack one cycle after mem_req
        add(vi(1,1,'h100,0,0,0,0,0,0),               vo(0,0,0,0,0,0,0,0,1,0,0));
        add(vi(1,1,'h100,0,0,0,0,0,0),               vo(1,0,'h100,0,0,0,0,0,1,0,0));
        add(vi(1,1,'h100,0,0,0,0,1,'h00500093),      vo(1,0,'h100,0,0,0,0,0,1,0,0));
        add(vi(1,0,0,0,0,0,0,0,0),                   vo(0,0,'h100,0,1,'h00500093,0,0,0,0,0));
        add(vi(1,0,0,0,0,0,0,0,0),                   vo(0,0,'h100,0,0,'h00500093,0,0,0,0,0));
        // load with immediate ack
        add(vi(1,0,0,1,0,'h40,0,0,0),                vo(0,0,'h100,0,0,'h00500093,0,0,0,1,0));
        add(vi(1,0,0,1,0,'h40,0,1,'hCAFEF00D),       vo(1,0,'h40,0,0,'h00500093,0,0,0,1,0));
        add(vi(1,0,0,0,0,0,0,0,0),                   vo(0,0,'h40,0,0,'h00500093,1,'hCAFEF00D,0,0,0));
        // store held through a slow ack
        add(vi(1,0,0,1,1,'h2000,'hDEADBEEF,0,0),     vo(0,0,'h40,0,0,'h00500093,0,'hCAFEF00D,0,1,0));
        add(vi(1,0,0,1,1,'h2000,'hDEADBEEF,0,0),     vo(1,1,'h2000,'hDEADBEEF,0,'h00500093,0,'hCAFEF00D,0,1,0));
        add(vi(1,0,0,1,1,'h2000,'hDEADBEEF,0,0),     vo(1,1,'h2000,'hDEADBEEF,0,'h00500093,0,'hCAFEF00D,0,1,0));
        add(vi(1,0,0,1,1,'h2000,'hDEADBEEF,0,0),     vo(1,1,'h2000,'hDEADBEEF,0,'h00500093,0,'hCAFEF00D,0,1,0));
        add(vi(1,0,0,1,1,'h2000,'hDEADBEEF,1,'h12345678), vo(1,1,'h2000,'hDEADBEEF,0,'h00500093,0,'hCAFEF00D,0,1,0));
        add(vi(1,0,0,0,0,0,0,0,0),                   vo(0,1,'h2000,'hDEADBEEF,0,'h00500093,1,0,0,0,0));
        add(vi(1,0,0,0,0,0,0,0,0),                   vo(0,1,'h2000,'hDEADBEEF,0,'h00500093,0,0,0,0,0));
        // stale ack after activity
        add(vi(1,0,0,0,0,0,0,1,'h0BADBAD0),          vo(0,1,'h2000,'hDEADBEEF,0,'h00500093,0,0,0,0,0));
        add(vi(1,0,0,0,0,0,0,0,0),                   vo(0,1,'h2000,'hDEADBEEF,0,'h00500093,0,0,0,0,0));
        // reset in the middle of a load, late ack afterwards
        add(vi(1,0,0,1,0,'h80,0,0,0),                vo(0,1,'h2000,'hDEADBEEF,0,'h00500093,0,0,0,1,0));
        add(vi(1,0,0,1,0,'h80,0,0,0),                vo(1,0,'h80,0,0,'h00500093,0,0,0,1,0));
        add(vi(0,0,0,0,0,0,0,0,0),                   vo(1,0,'h80,0,0,'h00500093,0,0,0,0,0));
        add(vi(1,0,0,0,0,0,0,1,'h55),                vo(0,0,0,0,0,0,0,0,0,0,0));
        add(vi(1,0,0,0,0,0,0,0,0),                   vo(0,0,0,0,0,0,0,0,0,0,0));
        // fetch after reset; req kept high in valid cycle becomes a new request
        add(vi(1,1,'h300,0,0,0,0,0,0),               vo(0,0,0,0,0,0,0,0,1,0,0));
        add(vi(1,1,'h300,0,0,0,0,1,'h77),            vo(1,0,'h300,0,0,0,0,0,1,0,0));
        add(vi(1,1,'h304,0,0,0,0,0,0),               vo(0,0,'h300,0,1,'h77,0,0,0,0,0));
        add(vi(1,1,'h304,0,0,0,0,0,0),               vo(0,0,'h300,0,0,'h77,0,0,1,0,0));
        add(vi(1,1,'h304,0,0,0,0,1,'h88),            vo(1,0,'h304,0,0,'h77,0,0,1,0,0));
        add(vi(1,0,0,0,0,0,0,0,0),                   vo(0,0,'h304,0,1,'h88,0,0,0,0,0));
    endfunction

    initial begin
        outs_t exp;
        applyIn('0);
        tick();
        tick();

        buildTable();
        foreach (tbl[i]) begin
            applyIn(tbl[i].stim);
            #2;
            chkOuts("vec", i, sample(), tbl[i].exp);
            tick();
        end

        // contested arbitrations: fetch retracts whenever dm wins, so its losses accumulate
        rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 6; r++) begin
            bit expIf;
            expIf = (r == 4);
            if_req = 1'b1; if_addr = 32'h1000 + 32'(r);
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000 + 32'(r); dm_wdata = '0;
            tick();
            chk32("starve_grant_addr", mem_addr, expIf ? 32'h1000 + 32'(r) : 32'h2000 + 32'(r));
            mem_ack = 1'b1; mem_rdata = 32'hA000 + 32'(r);
            tick();
            mem_ack = 1'b0; if_req = 1'b0; dm_req = 1'b0;
            chk32("starve_valid_pair", {30'b0, if_valid, dm_valid}, expIf ? 32'h2 : 32'h1);
            chk32("starve_rdata", expIf ? if_rdata : dm_rdata, 32'hA000 + 32'(r));
            tick();
        end

`ifdef MEM_ARB_TIMEOUT_EN
        begin
            int n;
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            // ack on the expiry cycle wins
            if_req = 1'b1; if_addr = 32'h400;
            tick();
            for (int b = 1; b < int'(TOUT); b++) begin
                chk32("to_req_held", 32'(mem_req), 32'h1);
                tick();
            end
            mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
            tick();
            mem_ack = 1'b0; if_req = 1'b0;
            chk32("to_ack_valid", 32'(if_valid), 32'h1);
            chk32("to_ack_rdata", if_rdata, 32'hA5A5A5A5);
            chk32("to_ack_buserr", 32'(bus_err), 32'h0);
            tick();
            // no ack at all
            if_req = 1'b1; if_addr = 32'h404;
            tick();
            n = 0;
            while (mem_req && n < 30) begin
                n++;
                tick();
            end
            if_req = 1'b0;
            chk32("to_busy_cycles", 32'(n), 32'(TOUT));
            chk32("to_exp_valid", 32'(if_valid), 32'h1);
            chk32("to_exp_rdata", if_rdata, 32'h0);
            chk32("to_exp_buserr", 32'(bus_err), 32'h1);
            tick();
            if_req = 1'b1; if_addr = 32'h408;
            tick();
            mem_ack = 1'b1; mem_rdata = 32'h1234;
            tick();
            mem_ack = 1'b0; if_req = 1'b0;
            chk32("to_after_rdata", if_rdata, 32'h1234);
            chk32("to_buserr_sticky", 32'(bus_err), 32'h1);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk32("to_buserr_reset", 32'(bus_err), 32'h0);
        end
`endif

        // randomized run against the reference model; cycle 0 resets both
        for (int c = 0; c < 3000; c++) begin
            rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            if (!(if_req && !m.ifValid)) begin
                if_req  = ($urandom_range(0, 2) == 0);
                if_addr = $urandom;
            end
            if (!(dm_req && !m.dmValid)) begin
                dm_req   = ($urandom_range(0, 2) == 0);
                dm_we    = ($urandom_range(0, 1) == 1);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            mem_ack   = m.memReq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            #2;
            if (c > 0) begin
                exp = m;
                exp.stallIf = if_req & ~m.ifValid;
                exp.stallDm = dm_req & ~m.dmValid;
                chkOuts("rand", c, sample(), exp);
            end
            modelStep();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
